// File: rtl/circle_disp_pkg.sv
// circle_disp_pkg: segment encodings and the pattern-select helper shared by
// the circle scan display. Segment order is {g,f,e,d,c,b,a}, active-low.
package circle_disp_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_UP    = 7'b0011100; // a,b,f,g lit: circle in upper half
   localparam seg_t SEG_DN    = 7'b0100011; // c,d,e,g lit: circle in lower half
   localparam seg_t SEG_FULL  = 7'b1000000; // a-f lit: bounce flash
   localparam seg_t SEG_BLANK = 7'h7F;      // everything off

   // Pattern for one digit slot: blank unless the slot is in its lit phase
   // and this digit holds the circle; the flash overrides the half-glyph.
   function automatic seg_t seg_select(input logic lit,
                                       input logic match,
                                       input logic row,
                                       input logic flash);
      seg_t seg;
      if (!lit || !match) begin
         seg = SEG_BLANK;
      end else if (flash) begin
         seg = SEG_FULL;
      end else if (row) begin
         seg = SEG_UP;
      end else begin
         seg = SEG_DN;
      end
      return seg;
   endfunction

endpackage

// File: rtl/counter.sv
// counter: wrapping up/down counter between LOW and HIGH with an enable.
// Exposes the next count so a consumer can register logic aligned with the
// value the counter will hold in the following cycle, and an overflow strobe
// that is high on the enabled cycle in which the counter wraps.
module counter #(
   parameter int               WIDTH = 4,
   parameter bit               DIR   = 1'b1,     // 1 = count up, 0 = count down
   parameter logic [WIDTH-1:0] LOW   = '0,
   parameter logic [WIDTH-1:0] HIGH  = '1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_d_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic             at_limit;

   assign at_limit = DIR ? (cnt_q == HIGH) : (cnt_q == LOW);
   assign ovf_o    = en_i & at_limit;
   assign cnt_d_o  = cnt_d;

   // Next count: step when enabled, wrap to the opposite limit at the end.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         if (DIR) begin
            cnt_d = at_limit ? LOW : cnt_q + 1'b1;
         end else begin
            cnt_d = at_limit ? HIGH : cnt_q - 1'b1;
         end
      end
   end

   // Count register; reset starts at the low limit for an up counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= DIR ? LOW : HIGH;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/circle_scan_display.sv
// circle_scan_display: scans NO_DISPLAYS common-anode digits, one per dwell
// slot, with an all-off blank phase at the start of every slot. The circle
// position is latched only on the last cycle of a frame so a frame never
// tears. Optional bounce flash is compiled in with `define CIRCLE_FLASH_EN.
module circle_scan_display
   import circle_disp_pkg::*;
#(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int REFRESH_HZ   = 1000,
   parameter int NO_DISPLAYS  = 6,
   parameter int BLANK_CYCLES = 16,
   parameter int FLASH_FRAMES = 64
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           row_i,
   input  logic [$clog2(NO_DISPLAYS)-1:0] col_i,
   output logic [6:0]                     seg_o,
   output logic [NO_DISPLAYS-1:0]         an_o
);

   localparam int DWELL = CLK_FREQ / (REFRESH_HZ * NO_DISPLAYS);
   localparam int DW_W  = $clog2(DWELL);
   localparam int CW    = $clog2(NO_DISPLAYS);

   // Parameter sanity checks at elaboration time.
   if (DWELL < 2) begin : g_bad_dwell
      $error("circle_scan_display: DWELL must be at least 2");
   end
   if (BLANK_CYCLES >= DWELL) begin : g_bad_blank
      $error("circle_scan_display: BLANK_CYCLES must be below DWELL");
   end
   if (FLASH_FRAMES < 1) begin : g_bad_flash
      $error("circle_scan_display: FLASH_FRAMES must be positive");
   end

   logic [DW_W-1:0]        dwell_d;
   logic                   dwell_ovf;
   logic [CW-1:0]          idx_d;
   logic                   frame_end;

   logic                   pos_row_q, pos_row_d;
   logic [CW-1:0]          pos_col_q, pos_col_d;
   logic                   flash_on;

   seg_t                   seg_q, seg_d;
   logic [NO_DISPLAYS-1:0] an_q, an_d;
   logic                   lit;

   // Cycle-within-slot counter; its wrap advances the digit.
   counter #(
      .WIDTH (DW_W),
      .DIR   (1'b1),
      .LOW   ('0),
      .HIGH  (DW_W'(DWELL - 1))
   ) u_dwell_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (1'b1),
      .cnt_d_o (dwell_d),
      .ovf_o   (dwell_ovf)
   );

   // Digit index; its wrap is the frame end (last cycle of the last digit).
   counter #(
      .WIDTH (CW),
      .DIR   (1'b1),
      .LOW   ('0),
      .HIGH  (CW'(NO_DISPLAYS - 1))
   ) u_digit_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (dwell_ovf),
      .cnt_d_o (idx_d),
      .ovf_o   (frame_end)
   );

   // Position capture: only on the frame-end cycle, out-of-range columns kept.
   always_comb begin
      pos_row_d = pos_row_q;
      pos_col_d = pos_col_q;
      if (frame_end) begin
         pos_row_d = row_i;
         pos_col_d = col_i;
      end
   end

   // Position register; reset shows the circle in the upper half of digit 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pos_row_q <= 1'b1;
         pos_col_q <= '0;
      end else begin
         pos_row_q <= pos_row_d;
         pos_col_q <= pos_col_d;
      end
   end

`ifdef CIRCLE_FLASH_EN
   localparam int FW = $clog2(FLASH_FRAMES + 1);

   logic [FW-1:0] flash_q, flash_d;

   // Bounce flash: reload on a row change at frame end, else count frames down.
   always_comb begin
      flash_d = flash_q;
      if (frame_end) begin
         if (row_i != pos_row_q) begin
            flash_d = FW'(FLASH_FRAMES);
         end else if (flash_q != '0) begin
            flash_d = flash_q - 1'b1;
         end
      end
   end

   // Flash counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         flash_q <= '0;
      end else begin
         flash_q <= flash_d;
      end
   end

   assign flash_on = (flash_d != '0);
`else
   assign flash_on = 1'b0;
`endif

   // Pin pattern for the coming cycle, built from the next counter and
   // position values so the registered pins line up with the slot count.
   always_comb begin
      lit  = (32'(dwell_d) >= BLANK_CYCLES);
      an_d = '1;
      if (lit) begin
         an_d[idx_d] = 1'b0;
      end
      seg_d = seg_select(lit, (idx_d == pos_col_d), pos_row_d, flash_on);
   end

   // Output registers; reset blanks the display immediately.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         seg_q <= SEG_BLANK;
         an_q  <= '1;
      end else begin
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign seg_o = seg_q;
   assign an_o  = an_q;

endmodule

// File: tb/tb_circle_scan_display.sv
// Directed bench for circle_scan_display with DWELL=4, BLANK_CYCLES=1,
// six digits (24-cycle frame). Flash frames are expected only when the
// bench is built with CIRCLE_FLASH_EN defined.
module tb_circle_scan_display;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       row_i = 1'b1;
   logic [2:0] col_i = 3'd0;
   logic [6:0] seg_o;
   logic [5:0] an_o;

   int checks = 0;
   int errors = 0;

`ifdef CIRCLE_FLASH_EN
   localparam bit FLASH = 1'b1;
`else
   localparam bit FLASH = 1'b0;
`endif

   circle_scan_display #(
      .CLK_FREQ     (2400),
      .REFRESH_HZ   (100),
      .NO_DISPLAYS  (6),
      .BLANK_CYCLES (1),
      .FLASH_FRAMES (2)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .row_i  (row_i),
      .col_i  (col_i),
      .seg_o  (seg_o),
      .an_o   (an_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input int cyc,
                      input logic [5:0] exp_an, input logic [6:0] exp_seg);
      checks++;
      assert (an_o === exp_an) else begin
         errors++;
         $error("FAIL %s cyc=%0d an_o=%b expected %b", tag, cyc, an_o, exp_an);
      end
      checks++;
      assert (seg_o === exp_seg) else begin
         errors++;
         $error("FAIL %s cyc=%0d seg_o=%b expected %b", tag, cyc, seg_o, exp_seg);
      end
   endtask

   // Walk ncyc cycles of one frame starting at frame cycle 0, checking the
   // pins each cycle. When toggle is set, col_i is driven to 4 during frame
   // cycles 5..10 and back to 2 afterwards.
   task automatic check_frame(input logic prow, input int pcol, input bit full,
                              input bit toggle, input int ncyc, input string tag);
      for (int c = 0; c < ncyc; c++) begin
         int d;
         logic [5:0] ea;
         logic [6:0] es;
         d = c / 4;
         if (c % 4 == 0) begin
            ea = 6'h3F;
            es = 7'h7F;
         end else begin
            ea = ~(6'b000001 << d);
            if (d == pcol) es = full ? 7'b1000000 : (prow ? 7'b0011100 : 7'b0100011);
            else           es = 7'h7F;
         end
         chk(tag, c, ea, es);
         if (toggle && c == 5)  col_i = 3'd4;
         if (toggle && c == 10) col_i = 3'd2;
         @(posedge clk_i);
         #1;
      end
   endtask

   initial begin
      // Held in reset: display dark.
      repeat (3) @(posedge clk_i);
      #1;
      chk("in_reset", 0, 6'h3F, 7'h7F);

      // Release; this is frame cycle 0. New position latched at frame end.
      rst_ni = 1'b1;
      row_i  = 1'b0;
      col_i  = 3'd3;
      check_frame(1'b1, 0, 1'b0, 1'b0, 24, "f0_reset_pos");

      row_i = 1'b1;
      col_i = 3'd2;
      check_frame(1'b0, 3, 1'b0, 1'b0, 24, "f1_dn_col3");

      // Mid-frame glitch to column 4 must never be displayed.
      check_frame(1'b1, 2, 1'b0, 1'b1, 24, "f2_toggle");

      col_i = 3'd7;
      check_frame(1'b1, 2, 1'b0, 1'b0, 24, "f3_after_toggle");

      // Column 7 is out of range: whole frame blank.
      col_i = 3'd1;
      check_frame(1'b1, 7, 1'b0, 1'b0, 24, "f4_out_of_range");

      // Reset at frame cycle 13 (digit 3 lit at that point).
      col_i = 3'd5;
      check_frame(1'b1, 1, 1'b0, 1'b0, 13, "f5_pre_reset");
      rst_ni = 1'b0;
      #1;
      chk("async_reset", 13, 6'h3F, 7'h7F);
      @(posedge clk_i);
      #1;
      chk("reset_hold", 14, 6'h3F, 7'h7F);
      rst_ni = 1'b1;

      // Scan restarts at digit 0 with the reset position.
      check_frame(1'b1, 0, 1'b0, 1'b0, 24, "r0_restart");

      row_i = 1'b0;
      check_frame(1'b1, 5, 1'b0, 1'b0, 24, "r1_up_col5");

      // Row flip latched: two flash frames when enabled, then the lower glyph.
      check_frame(1'b0, 5, FLASH, 1'b0, 24, "r2_flash1");
      check_frame(1'b0, 5, FLASH, 1'b0, 24, "r3_flash2");
      check_frame(1'b0, 5, 1'b0, 1'b0, 24, "r4_dn_col5");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
